ysyx_25030081_lsu: RTL and testbench
====================================

// Module: ysyx_25030081_lsu
// PURPOSE
//  Load/store unit: executes the memory access the control unit requests (mem_ren/mem_wen/mem_op).
//  Takes one request per transaction from the execute stage and drives a valid/ready data-memory bus.
//  Aligns store data and builds byte masks; extracts and sign/zero-extends load data.
//  Returns one completion pulse per request; the core stalls on !req_ready.
// PARAMETERS
//  TIMEOUT  255  max cycles in REQ+WAIT before abort with error; counter width = $clog2(TIMEOUT+1)
// PORTS
//  clk            in   1   core clock
//  rst            in   1   synchronous, active-high reset
//  req_valid      in   1   access request from execute stage
//  req_ready      out  1   1 = LSU in IDLE, request accepted this cycle
//  req_wen        in   1   1 = store, 0 = load
//  req_op         in   3   access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  req_addr       in   32  byte address (ALU result)
//  req_wdata      in   32  store data (rs2), right-aligned
//  resp_valid     out  1   1-cycle completion pulse
//  resp_rdata     out  32  extended load data; 0 for stores and errors
//  resp_err       out  1   misaligned, illegal op, or timeout; valid with resp_valid
//  mem_req_valid  out  1   bus request
//  mem_req_ready  in   1   bus accepts request
//  mem_req_wen    out  1   bus write enable
//  mem_req_addr   out  32  word-aligned address {req_addr[31:2],2'b00}
//  mem_req_wdata  out  32  lane-shifted store data
//  mem_req_wmask  out  4   byte enables; 4'b0000 on reads
//  mem_rsp_valid  in   1   bus response (read data or write ack)
//  mem_rsp_rdata  in   32  raw word from memory
// BEHAVIOUR
//  Reset: state=IDLE, counter=0. Outputs: req_ready=1, resp_valid=0, resp_err=0, resp_rdata=0,
//   mem_req_valid=0, mem_req_wen=0, mem_req_addr=0, mem_req_wdata=0, mem_req_wmask=0.
//  FSM: IDLE, REQ, WAIT, DONE.
//   IDLE: req_ready=1. On req_valid, latch wen/op/addr/wdata.
//    If the request is misaligned or illegal, go to DONE with err=1 and issue no bus access.
//     Misaligned: H/HU with addr[0]=1, or W with addr[1:0]!=0.
//     Illegal: op 011, 110 or 111.
//    Otherwise go to REQ.
//   REQ: mem_req_valid=1; address, data, mask and wen are driven from registers and stay stable.
//    On mem_req_ready, go to WAIT.
//   WAIT: on mem_rsp_valid, capture the extended rdata and go to DONE.
//    A response that arrives in the same cycle as mem_req_ready in REQ is legal.
//    In that case go directly REQ->DONE and capture the response.
//   DONE: resp_valid=1 for exactly one cycle, then go to IDLE.
//  Min latency: accept at cycle N, bus handshake at N+1, response at N+1 or later.
//   resp_valid is asserted the cycle after the response.
//   A request that fails the alignment/op check completes with resp_valid at N+1.
//  Store lanes: B: wmask=4'b0001<<addr[1:0], wdata={4{wdata[7:0]}}.
//   H: wmask=4'b0011<<addr[1:0], wdata={2{wdata[15:0]}}. W: wmask=4'b1111.
//  Load extraction: B/BU select byte addr[1:0]; H/HU select half addr[1].
//   B and H sign-extend; BU and HU zero-extend.
//  Timeout: the counter clears on entering REQ and increments each cycle in REQ or WAIT.
//   When it reaches TIMEOUT, go to DONE with resp_err=1 and resp_rdata=0.
//   mem_req_valid drops at that point. A late mem_rsp_valid arriving in IDLE is ignored.
//  req_valid is ignored while not in IDLE (req_ready=0); no queueing, one outstanding transaction.
//  rst asserted in any state: next cycle IDLE with all reset values. No resp_valid for the aborted access.
//  Stores: resp_rdata=0; completion waits on the write-ack mem_rsp_valid.
// STRUCTURE
//  Shared defines file: mem_op codes (LSU_OP_B/H/W/BU/HU) and FSM state encodings.
//   The control unit's mem_op is mapped onto these codes.
//  Sub-module ysyx_25030081_lsu_align (combinational), containing:
//   op/addr -> wmask, shifted wdata, misalign/illegal flag;
//   raw word -> extended rdata.
//  The top level holds the FSM, the request registers and the timeout counter.
// TESTING
//  1 Store SB: addr=0x8000_0003, wdata=0x0000_00AB, ready same cycle.
//    -> mem_req_addr=0x8000_0000, wmask=4'b1000, wdata=0xABABABAB; resp_valid, err=0.
//  2 Load LB: addr=0x...2, raw word=0x0080_0000.
//    -> resp_rdata=0xFFFF_FF80. Same access as LBU -> 0x0000_0080.
//  3 Misaligned LW: addr=0x...1.
//    -> no mem_req_valid ever; resp_valid at N+1 with resp_err=1, resp_rdata=0.
//  4 Backpressure: mem_req_ready low for 5 cycles, response 3 cycles later.
//    -> request signals stable throughout; one resp_valid; req_ready=0 until DONE->IDLE.
//  5 Timeout: TIMEOUT=8, no mem_rsp_valid.
//    -> resp_err=1 exactly 8 cycles after entering REQ; a later mem_rsp_valid is ignored.
//  6 rst asserted in WAIT.
//    -> next cycle IDLE, req_ready=1, no resp_valid; a following LW 0x...4 completes normally.

Source files
------------

// File: rtl/ysyx_25030081_lsu_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu_pkg
//  Desc     : Shared LSU access-size codes, FSM state encodings and helpers.
//  Revision : 1.0
// ============================================================================
package ysyx_25030081_lsu_pkg;

    typedef logic [2:0] lsu_op_t;

    localparam lsu_op_t c_LSU_OP_B  = 3'b000;
    localparam lsu_op_t c_LSU_OP_H  = 3'b001;
    localparam lsu_op_t c_LSU_OP_W  = 3'b010;
    localparam lsu_op_t c_LSU_OP_BU = 3'b100;
    localparam lsu_op_t c_LSU_OP_HU = 3'b101;

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_REQ  = 2'd1;
    localparam logic [1:0] c_ST_WAIT = 2'd2;
    localparam logic [1:0] c_ST_DONE = 2'd3;

    // Misaligned half/word access or an op code with no defined size.
    function automatic logic lsu_bad_access(input lsu_op_t op, input logic [1:0] off);
        case (op)
            c_LSU_OP_B, c_LSU_OP_BU: lsu_bad_access = 1'b0;
            c_LSU_OP_H, c_LSU_OP_HU: lsu_bad_access = off[0];
            c_LSU_OP_W:              lsu_bad_access = (off != 2'b00);
            default:                 lsu_bad_access = 1'b1;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_25030081_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu_req_if / ysyx_25030081_lsu_mem_if
//  Desc     : Execute-stage request channel and data-memory valid/ready bus.
//  Revision : 1.0
// ============================================================================
interface ysyx_25030081_lsu_req_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [2:0]  req_op;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_wen, req_op, req_addr, req_wdata,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );
    modport slave (
        input  req_valid, req_wen, req_op, req_addr, req_wdata,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

interface ysyx_25030081_lsu_mem_if;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_req_wen;
    logic [31:0] mem_req_addr;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wmask;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_rdata;

    modport master (
        output mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        input  mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
    modport slave (
        input  mem_req_valid, mem_req_wen, mem_req_addr, mem_req_wdata, mem_req_wmask,
        output mem_req_ready, mem_rsp_valid, mem_rsp_rdata
    );
endinterface
`default_nettype wire

// File: rtl/ysyx_25030081_lsu_align.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu_align
//  Desc     : Store lane/mask generation, access check and load extension.
//  Revision : 1.0
// ============================================================================
module ysyx_25030081_lsu_align
    import ysyx_25030081_lsu_pkg::*;
(
    input  wire  [2:0]  i_st_op,
    input  wire  [1:0]  i_st_off,
    input  wire         i_st_wen,
    input  wire  [31:0] i_st_wdata,
    output logic [3:0]  o_st_wmask,
    output logic [31:0] o_st_wdata,
    output logic        o_st_bad,
    input  wire  [2:0]  i_ld_op,
    input  wire  [1:0]  i_ld_off,
    input  wire  [31:0] i_ld_raw,
    output logic [31:0] o_ld_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_st_wmask = 4'b0000;
        o_st_wdata = i_st_wdata;
        o_st_bad   = lsu_bad_access(i_st_op, i_st_off);
        case (i_st_op)
            c_LSU_OP_B, c_LSU_OP_BU: begin
                o_st_wdata = {4{i_st_wdata[7:0]}};
                o_st_wmask = 4'b0001 << i_st_off;
            end
            c_LSU_OP_H, c_LSU_OP_HU: begin
                o_st_wdata = {2{i_st_wdata[15:0]}};
                o_st_wmask = 4'b0011 << i_st_off;
            end
            c_LSU_OP_W: o_st_wmask = 4'b1111;
            default:    o_st_wmask = 4'b0000;
        endcase
        if (!i_st_wen) begin
            o_st_wmask = 4'b0000;
        end
    end

    always_comb begin
        case (i_ld_off)
            2'd0:    w_byte = i_ld_raw[7:0];
            2'd1:    w_byte = i_ld_raw[15:8];
            2'd2:    w_byte = i_ld_raw[23:16];
            default: w_byte = i_ld_raw[31:24];
        endcase
        w_half = i_ld_off[1] ? i_ld_raw[31:16] : i_ld_raw[15:0];
        case (i_ld_op)
            c_LSU_OP_B:  o_ld_data = {{24{w_byte[7]}}, w_byte};
            c_LSU_OP_BU: o_ld_data = {24'h0, w_byte};
            c_LSU_OP_H:  o_ld_data = {{16{w_half[15]}}, w_half};
            c_LSU_OP_HU: o_ld_data = {16'h0, w_half};
            c_LSU_OP_W:  o_ld_data = i_ld_raw;
            default:     o_ld_data = 32'h0;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/ysyx_25030081_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : ysyx_25030081_lsu
//  Desc     : Load/store unit: one outstanding access on a valid/ready bus.
//  Revision : 1.0
// ============================================================================
module ysyx_25030081_lsu
    import ysyx_25030081_lsu_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input wire                       clk,
    input wire                       rst,
    ysyx_25030081_lsu_req_if.slave   core,
    ysyx_25030081_lsu_mem_if.master  mem
);

    localparam int c_CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]         r_state;
    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_inc;
    logic               w_timeout;
    logic               w_rsp_take;

    logic        r_wen;
    logic [2:0]  r_op;
    logic [1:0]  r_off;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wmask;
    logic [31:0] r_rdata;
    logic        r_err;

    logic [3:0]  w_st_wmask;
    logic [31:0] w_st_wdata;
    logic        w_st_bad;
    logic [31:0] w_ld_data;

    ysyx_25030081_lsu_align u_align (
        .i_st_op    (core.req_op),
        .i_st_off   (core.req_addr[1:0]),
        .i_st_wen   (core.req_wen),
        .i_st_wdata (core.req_wdata),
        .o_st_wmask (w_st_wmask),
        .o_st_wdata (w_st_wdata),
        .o_st_bad   (w_st_bad),
        .i_ld_op    (r_op),
        .i_ld_off   (r_off),
        .i_ld_raw   (mem.mem_rsp_rdata),
        .o_ld_data  (w_ld_data)
    );

    assign w_cnt_inc = r_cnt + c_CNT_W'(1);
    assign w_timeout = (w_cnt_inc == c_CNT_W'(TIMEOUT));
    // A response only counts in REQ if the request handshake completes with it.
    assign w_rsp_take = mem.mem_rsp_valid &&
                        ((r_state == c_ST_WAIT) || (r_state == c_ST_REQ && mem.mem_req_ready));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (core.req_valid) w_state_nxt = w_st_bad ? c_ST_DONE : c_ST_REQ;
            c_ST_REQ: begin
                if (w_rsp_take || w_timeout)  w_state_nxt = c_ST_DONE;
                else if (mem.mem_req_ready)   w_state_nxt = c_ST_WAIT;
            end
            c_ST_WAIT: if (w_rsp_take || w_timeout) w_state_nxt = c_ST_DONE;
            default:   w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_comb begin
        core.req_ready     = (r_state == c_ST_IDLE);
        core.resp_valid    = (r_state == c_ST_DONE);
        core.resp_err      = (r_state == c_ST_DONE) && r_err;
        core.resp_rdata    = (r_state == c_ST_DONE) ? r_rdata : 32'h0;
        mem.mem_req_valid  = (r_state == c_ST_REQ);
        mem.mem_req_wen    = r_wen;
        mem.mem_req_addr   = r_addr;
        mem.mem_req_wdata  = r_wdata;
        mem.mem_req_wmask  = r_wmask;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_wen   <= 1'b0;
            r_op    <= 3'b000;
            r_off   <= 2'b00;
            r_addr  <= 32'h0;
            r_wdata <= 32'h0;
            r_wmask <= 4'b0000;
            r_rdata <= 32'h0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (core.req_valid) begin
                        r_cnt   <= '0;
                        r_wen   <= core.req_wen;
                        r_op    <= core.req_op;
                        r_off   <= core.req_addr[1:0];
                        r_addr  <= {core.req_addr[31:2], 2'b00};
                        r_wdata <= w_st_wdata;
                        r_wmask <= w_st_wmask;
                        r_rdata <= 32'h0;
                        r_err   <= w_st_bad;
                    end
                end
                c_ST_REQ, c_ST_WAIT: begin
                    r_cnt <= w_cnt_inc;
                    if (w_rsp_take) begin
                        r_rdata <= r_wen ? 32'h0 : w_ld_data;
                        r_err   <= 1'b0;
                    end else if (w_timeout) begin
                        r_rdata <= 32'h0;
                        r_err   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_25030081_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ysyx_25030081_lsu
//  Desc     : Directed and randomized self-checking bench for the LSU.
//  Revision : 1.0
// ============================================================================
module tb_ysyx_25030081_lsu;

    localparam int TIMEOUT = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    ysyx_25030081_lsu_req_if u_core_if ();
    ysyx_25030081_lsu_mem_if u_mem_if ();

    ysyx_25030081_lsu #(.TIMEOUT(TIMEOUT)) u_dut (
        .clk  (clk),
        .rst  (rst),
        .core (u_core_if),
        .mem  (u_mem_if)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: observed 0x%08h expected 0x%08h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference rules written directly from the access-size definitions.
    function automatic bit ref_bad(input logic [2:0] op, input logic [31:0] addr);
        case (op)
            3'd0, 3'd4: return 1'b0;
            3'd1, 3'd5: return (addr % 2) != 0;
            3'd2:       return (addr % 4) != 0;
            default:    return 1'b1;
        endcase
    endfunction

    function automatic int ref_bytes(input logic [2:0] op);
        if (op == 3'd2) return 4;
        if (op == 3'd1 || op == 3'd5) return 2;
        return 1;
    endfunction

    function automatic logic [3:0] ref_wmask(input bit wen, input logic [2:0] op, input logic [31:0] addr);
        int m;
        if (!wen) return 4'b0000;
        m = ((1 << ref_bytes(op)) - 1) << (addr % 4);
        return 4'(m);
    endfunction

    function automatic logic [31:0] ref_wdata(input logic [2:0] op, input logic [31:0] wd);
        case (ref_bytes(op))
            1:       return (wd & 32'hFF) * 32'h0101_0101;
            2:       return (wd & 32'hFFFF) * 32'h0001_0001;
            default: return wd;
        endcase
    endfunction

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] raw);
        logic [31:0] sh;
        logic [31:0] val;
        sh = raw >> (8 * (addr % 4));
        case (op)
            3'd0, 3'd4: begin
                val = sh & 32'hFF;
                if (op == 3'd0 && val > 32'd127) val = val - 32'd256;
            end
            3'd1, 3'd5: begin
                val = sh & 32'hFFFF;
                if (op == 3'd1 && val > 32'd32767) val = val - 32'd65536;
            end
            default: val = raw;
        endcase
        return val;
    endfunction

    task automatic idle_inputs();
        u_core_if.req_valid    = 1'b0;
        u_core_if.req_wen      = 1'b0;
        u_core_if.req_op       = 3'd0;
        u_core_if.req_addr     = 32'h0;
        u_core_if.req_wdata    = 32'h0;
        u_mem_if.mem_req_ready = 1'b0;
        u_mem_if.mem_rsp_valid = 1'b0;
        u_mem_if.mem_rsp_rdata = 32'h0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready",  32'(u_core_if.req_ready),    32'd1);
        check("rst_resp_valid", 32'(u_core_if.resp_valid),   32'd0);
        check("rst_resp_err",   32'(u_core_if.resp_err),     32'd0);
        check("rst_resp_rdata", u_core_if.resp_rdata,        32'h0);
        check("rst_mreq_valid", 32'(u_mem_if.mem_req_valid), 32'd0);
        check("rst_mreq_wen",   32'(u_mem_if.mem_req_wen),   32'd0);
        check("rst_mreq_addr",  u_mem_if.mem_req_addr,       32'h0);
        check("rst_mreq_wdata", u_mem_if.mem_req_wdata,      32'h0);
        check("rst_mreq_wmask", 32'(u_mem_if.mem_req_wmask), 32'h0);
    endtask

    // Entered and left just after a falling edge with the LSU idle.
    // h: REQ cycle of the bus handshake, rd: cycles from handshake to response,
    // rst_at: REQ/WAIT cycle in which reset is applied (-1 = never).
    task automatic do_txn(input bit wen, input logic [2:0] op, input logic [31:0] addr,
                          input logic [31:0] wd, input logic [31:0] raw,
                          input int h, input int rd, input int rst_at);
        int  r;
        int  end_k;
        bit  tmo;
        r     = h + rd;
        tmo   = (r > TIMEOUT - 1);
        end_k = tmo ? TIMEOUT - 1 : r;

        check("idle_ready", 32'(u_core_if.req_ready), 32'd1);
        u_core_if.req_valid = 1'b1;
        u_core_if.req_wen   = wen;
        u_core_if.req_op    = op;
        u_core_if.req_addr  = addr;
        u_core_if.req_wdata = wd;
        @(posedge clk); @(negedge clk);

        if (ref_bad(op, addr)) begin
            idle_inputs();
            check("bad_resp_valid", 32'(u_core_if.resp_valid),   32'd1);
            check("bad_resp_err",   32'(u_core_if.resp_err),     32'd1);
            check("bad_resp_rdata", u_core_if.resp_rdata,        32'h0);
            check("bad_mreq_valid", 32'(u_mem_if.mem_req_valid), 32'd0);
            @(posedge clk); @(negedge clk);
            check("bad_after_ready", 32'(u_core_if.req_ready),  32'd1);
            check("bad_after_resp",  32'(u_core_if.resp_valid), 32'd0);
            return;
        end

        for (int k = 0; k <= end_k; k++) begin
            if (k == rst_at) begin
                idle_inputs();
                rst = 1'b1;
                @(posedge clk); @(negedge clk);
                rst = 1'b0;
                check_reset_outputs();
                @(posedge clk); @(negedge clk);
                check("post_rst_resp",  32'(u_core_if.resp_valid), 32'd0);
                check("post_rst_ready", 32'(u_core_if.req_ready),  32'd1);
                return;
            end
            check("busy_ready",      32'(u_core_if.req_ready),    32'd0);
            check("busy_resp_valid", 32'(u_core_if.resp_valid),   32'd0);
            check("mreq_valid",      32'(u_mem_if.mem_req_valid), 32'(k <= h));
            if (k <= h) begin
                check("mreq_addr",  u_mem_if.mem_req_addr,       addr & 32'hFFFF_FFFC);
                check("mreq_wen",   32'(u_mem_if.mem_req_wen),   32'(wen));
                check("mreq_wmask", 32'(u_mem_if.mem_req_wmask), 32'(ref_wmask(wen, op, addr)));
                if (wen) check("mreq_wdata", u_mem_if.mem_req_wdata, ref_wdata(op, wd));
            end
            // Unrelated request traffic while busy must be ignored.
            u_core_if.req_valid    = 1'($urandom);
            u_core_if.req_wen      = 1'($urandom);
            u_core_if.req_op       = 3'($urandom);
            u_core_if.req_addr     = $urandom;
            u_core_if.req_wdata    = $urandom;
            u_mem_if.mem_req_ready = (k == h);
            u_mem_if.mem_rsp_valid = (k == r);
            u_mem_if.mem_rsp_rdata = (k == r) ? raw : $urandom;
            @(posedge clk); @(negedge clk);
        end

        idle_inputs();
        check("done_resp_valid", 32'(u_core_if.resp_valid),   32'd1);
        check("done_resp_err",   32'(u_core_if.resp_err),     32'(tmo));
        check("done_resp_rdata", u_core_if.resp_rdata,
              (tmo || wen) ? 32'h0 : ref_load(op, addr, raw));
        check("done_mreq_valid", 32'(u_mem_if.mem_req_valid), 32'd0);
        check("done_ready",      32'(u_core_if.req_ready),    32'd0);
        @(posedge clk); @(negedge clk);
        check("after_ready", 32'(u_core_if.req_ready),  32'd1);
        check("after_resp",  32'(u_core_if.resp_valid), 32'd0);
        if (tmo) begin
            u_mem_if.mem_rsp_valid = 1'b1;
            u_mem_if.mem_rsp_rdata = $urandom;
            @(posedge clk); @(negedge clk);
            u_mem_if.mem_rsp_valid = 1'b0;
            check("late_rsp_resp",  32'(u_core_if.resp_valid),   32'd0);
            check("late_rsp_ready", 32'(u_core_if.req_ready),    32'd1);
            check("late_rsp_mreq",  32'(u_mem_if.mem_req_valid), 32'd0);
        end
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(posedge clk); @(negedge clk);

        do_txn(1'b1, 3'd0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 1, -1);
        do_txn(1'b0, 3'd0, 32'h8000_0002, 32'h0, 32'h0080_0000, 0, 0, -1);
        do_txn(1'b0, 3'd4, 32'h8000_0002, 32'h0, 32'h0080_0000, 1, 2, -1);
        do_txn(1'b0, 3'd1, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 0, 1, -1);
        do_txn(1'b0, 3'd5, 32'h8000_0006, 32'h0, 32'h8001_7FFF, 0, 1, -1);
        do_txn(1'b0, 3'd2, 32'h8000_0001, 32'h0, 32'h0, 0, 0, -1);
        do_txn(1'b0, 3'd3, 32'h8000_0000, 32'h0, 32'h0, 0, 0, -1);
        do_txn(1'b1, 3'd1, 32'h8000_0002, 32'h1234_BEEF, 32'h0, 5, 2, -1);
        do_txn(1'b0, 3'd2, 32'h8000_0010, 32'h0, 32'hCAFE_BABE, 5, 3, -1);
        do_txn(1'b0, 3'd2, 32'h8000_0020, 32'h0, 32'h1111_2222, 0, 1000, -1);
        do_txn(1'b1, 3'd2, 32'h8000_0024, 32'hDEAD_BEEF, 32'h0, 1000, 0, -1);
        do_txn(1'b0, 3'd2, 32'h8000_0028, 32'h0, 32'h3333_4444, 7, 0, -1);
        do_txn(1'b0, 3'd2, 32'h8000_0030, 32'h0, 32'h5555_6666, 0, 1000, 2);
        do_txn(1'b0, 3'd2, 32'h8000_0004, 32'h0, 32'h7777_8888, 0, 1, -1);

        for (int i = 0; i < 80; i++) begin
            do_txn(1'($urandom), 3'($urandom_range(0, 7)), $urandom, $urandom, $urandom,
                   $urandom_range(0, 4),
                   ($urandom_range(0, 7) == 0) ? 1000 : $urandom_range(0, 4), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed no end of stimulus, expected completion");
        $fatal(1, "bench watchdog expired");
    end

endmodule
`default_nettype wire
